// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-AHB-Lite bridge.
package spi_bridge_pkg;

    typedef enum logic [2:0] {
        StCmd,
        StAddr,
        StWdata,
        StAhbAddr,
        StAhbData,
        StTurn,
        StRdata,
        StSkip
    } state_t;

    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] SKIP_BYTE     = 8'hFF;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/spi_sck_sync.sv
// Synchronises raw sck/cs_n into clk and turns every eighth sck rise into a byte strobe.
module spi_sck_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic cs_n,
    output logic cs_high,
    output logic byte_stb
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_prev;
    logic [2:0]             bitcnt;
    logic                   sck_rise;

    assign cs_high  = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_sync[SYNC_STAGES-1] && !sck_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_prev <= 1'b0;
            bitcnt   <= 3'd0;
            byte_stb <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_prev <= sck_sync[SYNC_STAGES-1];
            byte_stb <= 1'b0;
            if (cs_high) begin
                bitcnt <= 3'd0;
            end else if (sck_rise) begin
                bitcnt <= bitcnt + 3'd1;
                byte_stb <= (bitcnt == 3'd7);
            end
        end
    end

endmodule

// File: rtl/spi_ahb_bridge.sv
// Decodes SPI command frames into single-word AHB-Lite transfers and serves read-back bytes.
module spi_ahb_bridge
    import spi_bridge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        cs_n,
    input  logic [7:0]  spi_q,
    output logic [7:0]  spi_d,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    output logic        busy
);

    state_t      state;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  byte_idx;
    logic        is_write;
    logic        cs_high;
    logic        byte_stb;

    spi_sck_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .sck     (sck),
        .cs_n    (cs_n),
        .cs_high (cs_high),
        .byte_stb(byte_stb)
    );

    assign HSIZE = HSIZE_WORD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StCmd;
            addr     <= '0;
            data     <= '0;
            byte_idx <= '0;
            is_write <= 1'b0;
            spi_d    <= IDLE_BYTE;
            HADDR    <= '0;
            HTRANS   <= HTRANS_IDLE;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
            busy     <= 1'b0;
        end else if (cs_high && state != StAhbAddr && state != StAhbData) begin
            // An AHB transfer in flight always finishes before the frame is dropped.
            state    <= StCmd;
            byte_idx <= '0;
            spi_d    <= IDLE_BYTE;
        end else begin
            unique case (state)
                StCmd: if (byte_stb) begin
                    byte_idx <= '0;
                    if (spi_q == CMD_WRITE || spi_q == CMD_READ) begin
                        is_write <= (spi_q == CMD_WRITE);
                        state    <= StAddr;
                    end else begin
                        state <= StSkip;
                        spi_d <= SKIP_BYTE;
                    end
                end
                StAddr: if (byte_stb) begin
                    addr     <= {addr[23:0], spi_q};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        if (is_write) begin
                            state <= StWdata;
                        end else begin
                            state  <= StAhbAddr;
                            HADDR  <= {addr[23:0], spi_q};
                            HWRITE <= 1'b0;
                            HTRANS <= HTRANS_NONSEQ;
                            busy   <= 1'b1;
                        end
                    end
                end
                StWdata: if (byte_stb) begin
                    data     <= {data[23:0], spi_q};
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state  <= StAhbAddr;
                        HADDR  <= addr;
                        HWDATA <= {data[23:0], spi_q};
                        HWRITE <= 1'b1;
                        HTRANS <= HTRANS_NONSEQ;
                        busy   <= 1'b1;
                    end
                end
                StAhbAddr: if (HREADY) begin
                    HTRANS <= HTRANS_IDLE;
                    state  <= StAhbData;
                end
                StAhbData: if (HREADY) begin
                    busy <= 1'b0;
                    if (is_write) begin
                        state <= StSkip;
                    end else begin
                        data  <= HRDATA;
                        spi_d <= HRDATA[31:24];
                        state <= StTurn;
                    end
                end
                // The slave latches spi_d as each byte ends, so advance one byte ahead.
                StTurn: if (byte_stb) begin
                    spi_d    <= data[23:16];
                    byte_idx <= '0;
                    state    <= StRdata;
                end
                StRdata: if (byte_stb) begin
                    byte_idx <= byte_idx + 2'd1;
                    unique case (byte_idx)
                        2'd0: spi_d <= data[15:8];
                        2'd1: spi_d <= data[7:0];
                        2'd2: spi_d <= IDLE_BYTE;
                        2'd3: state <= StSkip;
                    endcase
                end
                StSkip: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ahb_bridge.sv
// Scoreboard bench: SPI host/slave model, AHB-Lite memory with wait states, reference memory.
module tb_spi_ahb_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic [7:0]  spi_q = 8'h00;
    logic [7:0]  spi_d;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, busy;
    logic [2:0]  HSIZE;

    int n_chk = 0;
    int n_fail = 0;
    int n_xfer = 0;
    int exp_xfer = 0;
    int ws = 0;
    int pre_ws = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          busy_len;
    } ahb_exp_t;

    ahb_exp_t    exp_ahb[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  obs_rx[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] addr_set[4] = '{32'h2000_0010, 32'h2000_0100, 32'h4000_03F0, 32'h0000_0008};

    always #5 clk = ~clk;

    spi_ahb_bridge #(
        .SYNC_STAGES(2),
        .IDLE_BYTE  (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sck   (sck),
        .cs_n  (cs_n),
        .spi_q (spi_q),
        .spi_d (spi_d),
        .HADDR (HADDR),
        .HTRANS(HTRANS),
        .HWRITE(HWRITE),
        .HSIZE (HSIZE),
        .HWDATA(HWDATA),
        .HRDATA(HRDATA),
        .HREADY(HREADY),
        .busy  (busy)
    );

    // AHB-Lite memory slave: pre_ws wait cycles before accepting NONSEQ, ws in the data phase.
    logic [31:0] mem [256] = '{default: 32'h0};
    logic        dph = 1'b0;
    logic        dwr = 1'b0;
    logic [31:0] daddr = 32'h0;
    int          wcnt = 0;
    int          pcnt = 0;

    assign HREADY = dph ? (wcnt == 0) : !(HTRANS == 2'b10 && pcnt < pre_ws);
    assign HRDATA = (dph && !dwr) ? mem[daddr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            dph  <= 1'b0;
            wcnt <= 0;
            pcnt <= 0;
        end else begin
            if (dph && wcnt != 0) wcnt <= wcnt - 1;
            if (dph && wcnt == 0) begin
                dph <= 1'b0;
                if (dwr) mem[daddr[9:2]] <= HWDATA;
            end
            if (HREADY && HTRANS == 2'b10) begin
                dph   <= 1'b1;
                daddr <= HADDR;
                dwr   <= HWRITE;
                wcnt  <= ws;
                pcnt  <= 0;
            end else if (HTRANS == 2'b10) begin
                pcnt <= pcnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // AHB monitor: pops the expected transfer whenever an address phase is accepted.
    initial begin
        ahb_exp_t    e;
        logic        in_dph = 1'b0;
        logic        wwr = 1'b0;
        logic [31:0] wexp = 32'h0;
        int          blen = 0;
        int          bexp = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_dph = 1'b0;
                blen   = 0;
                bexp   = -1;
            end else begin
                if (busy) begin
                    blen++;
                end else if (blen > 0) begin
                    if (bexp >= 0) check("busy_len", 32'(blen), 32'(bexp));
                    blen = 0;
                    bexp = -1;
                end
                if (in_dph && HREADY) begin
                    in_dph = 1'b0;
                    if (wwr) check("hwdata", HWDATA, wexp);
                end
                if (HTRANS == 2'b10 && HREADY) begin
                    n_xfer++;
                    if (exp_ahb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got NONSEQ at %h, expected none", HADDR);
                    end else begin
                        e = exp_ahb.pop_front();
                        check("haddr", HADDR, e.addr);
                        check("hwrite", 32'(HWRITE), 32'(e.wr));
                        check("hsize", 32'(HSIZE), 32'h2);
                        in_dph = 1'b1;
                        wwr    = e.wr;
                        wexp   = e.wdata;
                        bexp   = e.busy_len;
                    end
                end
            end
        end
    end

    // Read-back monitor: compares every byte the host shifted in against the model.
    initial begin
        logic [7:0] o;
        forever begin
            @(negedge clk);
            while (obs_rx.size() > 0) begin
                o = obs_rx.pop_front();
                if (exp_rx.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rx: got %h, expected no byte", o);
                end else begin
                    check("rx_byte", 32'(o), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    // SPI host plus slave shift register: the slave latches spi_d on each byte's 8th rise.
    task automatic spi_frame(input logic [7:0] tx[$], input int lo, input int hi);
        logic [7:0] shreg;
        @(negedge clk);
        cs_n = 1'b0;
        shreg = spi_d;
        #80;
        for (int k = 0; k < tx.size(); k++) begin
            for (int b = 0; b < 8; b++) begin
                sck = 1'b1;
                if (b == 7) begin
                    spi_q = tx[k];
                    if (k >= lo && k <= hi) obs_rx.push_back(shreg);
                    shreg = spi_d;
                end
                #80;
                sck = 1'b0;
                #80;
            end
        end
        cs_n = 1'b1;
        #400;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int w, input int p,
                            input bit commit);
        logic [7:0] tx[$];
        ahb_exp_t   e;
        ws = w;
        pre_ws = p;
        tx.push_back(8'h02);
        for (int i = 3; i >= 0; i--) tx.push_back(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) tx.push_back(d[i*8 +: 8]);
        e.addr = a;
        e.wr = 1'b1;
        e.wdata = d;
        e.busy_len = commit ? 2 + w + p : -1;
        exp_ahb.push_back(e);
        exp_xfer++;
        if (commit) ref_mem[a] = d;
        spi_frame(tx, 99, -1);
    endtask

    // late=1: data phase outlasts the turnaround byte, so the data arrives one byte later.
    task automatic do_read(input logic [31:0] a, input int w, input int p, input int late);
        logic [7:0]  tx[$];
        logic [31:0] d;
        ahb_exp_t    e;
        ws = w;
        pre_ws = p;
        d = ref_rd(a);
        tx.push_back(8'h03);
        for (int i = 3; i >= 0; i--) tx.push_back(a[i*8 +: 8]);
        for (int i = 0; i < 6 + late; i++) tx.push_back(8'($urandom));
        e.addr = a;
        e.wr = 1'b0;
        e.wdata = 32'h0;
        e.busy_len = 2 + w + p;
        exp_ahb.push_back(e);
        exp_xfer++;
        for (int i = 0; i <= late; i++) exp_rx.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_rx.push_back(d[i*8 +: 8]);
        exp_rx.push_back(8'hA5);
        spi_frame(tx, 5, 10 + late);
    endtask

    initial begin
        logic [7:0] tx[$];
        bit         ok;
        #2ms;
        $display("FAIL watchdog: got no end of test, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  tx[$];
        logic [31:0] a;
        bit          ok;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        check("rst_spi_d", 32'(spi_d), 32'hA5);
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        do_write(32'h2000_0010, 32'hCAFE_F00D, 0, 0, 1'b1);
        do_read(32'h2000_0010, 0, 0, 0);
        do_read(32'h2000_0010, 3, 3, 0);

        // Frame dropped after two address bytes, then a normal write.
        tx = '{};
        tx.push_back(8'h02);
        tx.push_back(8'h20);
        tx.push_back(8'h00);
        spi_frame(tx, 99, -1);
        do_write(32'h2000_0100, 32'h1234_5678, 1, 0, 1'b1);

        // Unknown command: 0xFF for the rest of the frame, no bus traffic.
        tx = '{};
        tx.push_back(8'h7E);
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        for (int i = 2; i <= 8; i++) exp_rx.push_back(8'hFF);
        spi_frame(tx, 2, 8);
        do_read(32'h2000_0100, 0, 0, 0);

        do_read(32'h2000_0010, 140, 0, 1);

        for (int n = 0; n < 10; n++) begin
            a = addr_set[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
            else
                do_read(a, $urandom_range(0, 4), $urandom_range(0, 3), 0);
        end

        // Reset during a stretched data phase.
        do_write(32'h4000_03F0, 32'hDEAD_0001, 200, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = busy && HTRANS == 2'b00;
        end
        check("reach_data_phase", 32'(ok), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_htrans", 32'(HTRANS), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_spi_d", 32'(spi_d), 32'hA5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        do_read(32'h4000_03F0, 0, 0, 0);
        do_read(32'h2000_0100, 2, 1, 0);

        repeat (50) @(negedge clk);
        check("ahb_exp_left", 32'(exp_ahb.size()), 32'h0);
        check("rx_exp_left", 32'(exp_rx.size()), 32'h0);
        check("xfer_count", 32'(n_xfer), 32'(exp_xfer));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
